// File: rtl/sar_adc_if.sv
// Bus between the SAR controller and its environment: the conversion
// request side and the resistor-string DAC, which returns vdac for the code q.
// Handshake: the requester raises start while busy is low. A start seen
// while busy is high, or in the done cycle, is dropped and never queued.
// done is a one-cycle strobe that marks dout as freshly valid. dout then
// holds its value until the next done.
// The master modport is the environment (requester plus DAC). The slave
// modport is the controller.
interface sar_adc_if #(
  parameter int N = 3
);
  logic         start;
  real          vin;
  real          vdac;
  logic [N-1:0] q;
  logic         busy;
  logic         done;
  logic [N-1:0] dout;

  modport master (
    output start, vin, vdac,
    input  q, busy, done, dout
  );

  modport slave (
    input  start, vin, vdac,
    output q, busy, done, dout
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller for a real-valued (RNM) DAC.
// It samples vin, binary-searches N trial codes against vdac and then
// publishes the result on dout with a one-cycle done strobe.
// Optional feature macro SAR_CONT_EN: when it is defined, DONE goes straight
// back to SAMPLE (continuous conversion). By default the design is
// single-shot.
module sar_adc_ctrl #(
  parameter int N = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  sar_adc_if.slave    bus,
  output logic [1:0]  state_dbg
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e        state, state_n;
  logic [N-1:0]  q_r, q_n;
  logic [N-1:0]  dout_r, dout_n;
  logic [IW-1:0] i_r, i_n, i_dec;
  real           vhold, vhold_n;
  logic          keep;
  logic          busy_c, done_c;

  assign i_dec = i_r - IW'(1);

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q_r    <= '0;
      dout_r <= '0;
      i_r    <= '0;
      vhold  <= 0.0;
    end else begin
      state  <= state_n;
      q_r    <= q_n;
      dout_r <= dout_n;
      i_r    <= i_n;
      vhold  <= vhold_n;
    end
  end

  // Next-state, binary-search step and Moore outputs
  always_comb begin
    state_n = state;
    q_n     = q_r;
    dout_n  = dout_r;
    i_n     = i_r;
    vhold_n = vhold;
    keep    = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = SAMPLE;
      end
      SAMPLE: begin
        busy_c       = 1'b1;
        vhold_n      = bus.vin;
        q_n          = '0;
        q_n[N-1]     = 1'b1;
        i_n          = IW'(N - 1);
        state_n      = CONVERT;
      end
      CONVERT: begin
        busy_c = 1'b1;
        // vdac reflects the q driven during this cycle; ties keep the bit
        keep      = (vhold >= bus.vdac);
        q_n[i_r]  = keep;
        if (i_r != '0) begin
          q_n[i_dec] = 1'b1;
          i_n        = i_dec;
        end else begin
          // Load dout on entry so the new value coincides with done
          dout_n  = q_n;
          state_n = DONE;
        end
      end
      DONE: begin
        done_c = 1'b1;
`ifdef SAR_CONT_EN
        state_n = SAMPLE;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.q     = q_r;
  assign bus.dout  = dout_r;
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign state_dbg = state;

endmodule
